// File: rtl/pfb_pkg.sv
// pfb_pkg: shared widths, saturation limits and the round/saturate helper for the PFB output stage
package pfb_pkg;
  localparam int PFB_IN_W = 48;
  localparam int PFB_OUT_W = 16;
  localparam int PFB_TUSER_W = 11;
  localparam logic signed [PFB_OUT_W-1:0] PFB_SAT_MAX = 16'sh7FFF;
  localparam logic signed [PFB_OUT_W-1:0] PFB_SAT_MIN = 16'sh8000;
  // x arrives sign-extended to 64 bits so the rounded quotient can never wrap
  function automatic logic [32:0] pfb_round_sat(input logic signed [63:0] x, input int shift, input int out_w);
    logic signed [63:0] frac, half, q, hi, lo;
    frac = x & ((64'sd1 <<< shift) - 64'sd1);
    half = 64'sd1 <<< (shift - 1);
    q = (x >>> shift) + ((frac > half || (frac == half && x[shift])) ? 64'sd1 : 64'sd0);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return q > hi ? {1'b1, 32'(hi)} : q < lo ? {1'b1, 32'(lo)} : {1'b0, 32'(q)};
  endfunction
endpackage

// File: rtl/pfb_quant_fifo.sv
// pfb_quant_fifo: first-word-fall-through FIFO with occupancy count
module pfb_quant_fifo #(
  parameter int W = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wp_q] <= wr_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(wr_en_i);
      rp_q <= rp_q + AW'(rd_en_i);
      cnt_q <= cnt_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_en_i);
    end
  assign valid_o = cnt_q != '0;
  assign rd_data_o = valid_o ? mem_q[rp_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/pfb_output_quant.sv
// pfb_output_quant: convergent-round, saturate and buffer the final MAC output onto AXI-Stream; PFB_SAT_CNT_EN adds a saturation counter
module pfb_output_quant import pfb_pkg::*; #(
  parameter int IN_W = PFB_IN_W,
  parameter int OUT_W = PFB_OUT_W,
  parameter int SHIFT = 24,
  parameter int TUSER_W = PFB_TUSER_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef PFB_SAT_CNT_EN
  input  logic                     sat_clr,
  output logic [15:0]              sat_count,
`endif
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic signed [IN_W-1:0]   s_tdata,
  input  logic [TUSER_W-1:0]       s_tuser,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [OUT_W-1:0]         m_tdata,
  output logic [TUSER_W-1:0]       m_tuser,
  output logic                     m_tlast
);
  localparam int FW = OUT_W + TUSER_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic v1_q, v2_q, s_tready_q, s_tready_d, in_xfer, out_xfer;
  logic signed [IN_W-1:0] d1_q;
  logic [TUSER_W:0] sb1_q;
  logic [FW-1:0] d2_q, d2_d, head;
  logic [CW-1:0] cnt;
  logic signed [63:0] x64;
  assign in_xfer = s_tvalid && s_tready_q;
  assign out_xfer = m_tvalid && m_tready;
  assign x64 = 64'(d1_q);
  assign d2_d = {OUT_W'(pfb_round_sat(x64, SHIFT, OUT_W)), sb1_q};
  // every accepted sample is already owed a FIFO slot, so stages never need to stall
  assign s_tready_d = int'(cnt) + int'(v1_q) + int'(v2_q) + int'(in_xfer) - int'(out_xfer) < FIFO_DEPTH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d1_q <= '0;
      sb1_q <= '0;
      d2_q <= '0;
      s_tready_q <= 1'b0;
    end else begin
      v1_q <= in_xfer;
      v2_q <= v1_q;
      d1_q <= s_tdata;
      sb1_q <= {s_tuser, s_tlast};
      d2_q <= d2_d;
      s_tready_q <= s_tready_d;
    end
  pfb_quant_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en_i(v2_q),
    .wr_data_i(d2_q),
    .rd_en_i(out_xfer),
    .rd_data_o(head),
    .valid_o(m_tvalid),
    .count_o(cnt)
  );
  assign {m_tdata, m_tuser, m_tlast} = head;
  assign s_tready = s_tready_q;
`ifdef PFB_SAT_CNT_EN
  logic [15:0] sat_count_q;
  logic sat_d;
  assign sat_d = 1'(pfb_round_sat(x64, SHIFT, OUT_W) >> 32);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_count_q <= '0;
    else if (sat_clr) sat_count_q <= '0;
    else if (v1_q && sat_d && sat_count_q != 16'hFFFF) sat_count_q <= sat_count_q + 16'd1;
  assign sat_count = sat_count_q;
`endif
endmodule

// File: tb/tb_pfb_output_quant.sv
// tb_pfb_output_quant: scoreboard bench for rounding, saturation, backpressure, sideband and reset
module tb_pfb_output_quant;
  logic clk = 0, rst_n = 1, s_tvalid = 0, s_tlast = 0, m_tready = 0;
  logic s_tready, m_tvalid, m_tlast;
  logic [47:0] s_tdata = '0;
  logic [10:0] s_tuser = '0, m_tuser;
  logic [15:0] m_tdata;
`ifdef PFB_SAT_CNT_EN
  logic sat_clr = 0;
  logic [15:0] sat_count;
`endif
  typedef struct {logic [63:0] exp; int t; bit lat;} item_t;
  item_t sb[$];
  item_t mon_it;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] cur_exp = '0;
  bit cur_lat = 0;

  pfb_output_quant dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PFB_SAT_CNT_EN
    .sat_clr(sat_clr),
    .sat_count(sat_count),
`endif
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tuser(s_tuser),
    .s_tlast(s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tuser(m_tuser),
    .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [47:0] x);
    longint v, q, f;
    v = longint'(signed'(x));
    q = v >>> 24;
    f = v - (q <<< 24);
    if (f > 64'sh800000 || (f == 64'sh800000 && q[0])) q = q + 1;
    return q > 32767 ? 16'h7FFF : q < -32768 ? 16'h8000 : q[15:0];
  endfunction

  always @(negedge clk)
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) chk("unexpected_output", {36'd0, m_tdata, m_tuser, m_tlast}, 64'hDEAD);
      else begin
        mon_it = sb.pop_front();
        chk("out_sample", {36'd0, m_tdata, m_tuser, m_tlast}, mon_it.exp);
        if (mon_it.lat) chk("latency", 64'(cyc - mon_it.t), 64'd2);
      end
    end

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = s_tvalid && s_tready;
    if (acc) sb.push_back('{exp: cur_exp, t: cyc + 1, lat: cur_lat});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] x, input logic [10:0] u, input logic l, input logic [15:0] e, input bit lat);
    bit acc = 0;
    s_tvalid = 1; s_tdata = x; s_tuser = u; s_tlast = l;
    cur_exp = {36'd0, e, u, l}; cur_lat = lat;
    for (int i = 0; i < 50 && !acc; i++) tick(acc);
    chk("accept", 64'(acc), 64'd1);
    s_tvalid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic ramp(input int k);
    s_tdata = 48'(k) << 24; s_tuser = 11'(k); s_tlast = k[0];
    cur_exp = {36'd0, 16'(k), 11'(k), k[0]}; cur_lat = 0;
  endtask

  task automatic rnd_sample(input int i);
    logic [63:0] r;
    r = {$urandom, $urandom};
    s_tdata = {{8{r[39]}}, r[39:0]}; s_tuser = 11'(i % 8); s_tlast = (i % 8 == 7);
    cur_exp = {36'd0, model(s_tdata), s_tuser, s_tlast}; cur_lat = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k, n, i;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
`ifdef PFB_SAT_CNT_EN
    chk("rst_sat_count", 64'(sat_count), 64'd0);
`endif
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    chk("tready_after_reset", 64'(s_tready), 64'd1);
    m_tready = 1;
    send(48'h000001800000, 11'h001, 1'b0, 16'h0002, 1); drain();
    send(48'h000002800000, 11'h002, 1'b1, 16'h0002, 1); drain();
    send(48'hFFFFFE800000, 11'h003, 1'b0, 16'hFFFE, 1); drain();
    send(48'h000003C00001, 11'h004, 1'b1, 16'h0004, 1); drain();
    send(48'h008000000000, 11'h005, 1'b0, 16'h7FFF, 0);
    send(48'hFF7F00000000, 11'h006, 1'b1, 16'h8000, 0);
    drain();
`ifdef PFB_SAT_CNT_EN
    chk("sat_count", 64'(sat_count), 64'd2);
    sat_clr = 1;
    @(posedge clk);
    #1 sat_clr = 0;
    chk("sat_count_clr", 64'(sat_count), 64'd0);
`endif
    m_tready = 0;
    k = 100; n = 0;
    ramp(k);
    s_tvalid = 1;
    repeat (10) begin
      tick(acc);
      if (acc) begin n++; k++; ramp(k); end
    end
    chk("bp_accepted", 64'(n), 64'd4);
    chk("bp_tready_low", 64'(s_tready), 64'd0);
    m_tready = 1;
    repeat (12) begin
      tick(acc);
      if (acc) begin k++; ramp(k); end
      chk("bp_no_gap", 64'(m_tvalid), 64'd1);
    end
    s_tvalid = 0;
    drain();
    i = 0;
    rnd_sample(0);
    s_tvalid = 1;
    for (int c = 0; c < 500 && i < 16; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) begin i++; rnd_sample(i); end
    end
    s_tvalid = 0;
    chk("sideband_sent", 64'(i), 64'd16);
    m_tready = 1;
    drain();
    m_tready = 0;
    for (int j = 1; j <= 3; j++) send(48'(j) << 24, 11'(j), 1'b0, 16'(j), 0);
    repeat (3) tick(acc);
    rst_n = 0;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_tready_held", 64'(s_tready), 64'd0);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("midrst_tready_release", 64'(s_tready), 64'd1);
    m_tready = 1;
    repeat (8) tick(acc);
    chk("midrst_no_stale", 64'(m_tvalid), 64'd0);
    send(48'h000005000000, 11'h7FF, 1'b1, 16'h0005, 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
